// File: rtl/scaler_cfg_sequencer_pkg.sv
// Shared constants, state encoding and configuration record for the scaler
// configuration sequencer.
package scaler_cfg_pkg;

  localparam int FRAC_W_DEF = 16;

  localparam logic [11:0] OUT_W_1080P = 12'd1920;
  localparam logic [11:0] OUT_H_1080P = 12'd1080;
  localparam logic [11:0] OUT_W_4K    = 12'd3840;
  localparam logic [11:0] OUT_H_4K    = 12'd2160;

  localparam logic [11:0] RST_X_LEN  = 12'd640;
  localparam logic [11:0] RST_Y_LEN  = 12'd480;
  localparam logic [8:0]  RST_BI_A   = 9'd128;
  localparam int          RST_STEP_X = 21845;
  localparam int          RST_STEP_Y = 29127;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PENDING,
    ST_HALT,
    ST_DIV_X,
    ST_DIV_Y,
    ST_COMMIT,
    ST_RELEASE
  } state_e;

  typedef struct packed {
    logic [11:0] x_len;
    logic [11:0] y_len;
    logic [1:0]  algorithm;
    logic        vid_format;
    logic [8:0]  bi_a;
  } cfg_t;

  localparam cfg_t RST_CFG = '{x_len: RST_X_LEN, y_len: RST_Y_LEN, algorithm: 2'd0,
                               vid_format: 1'b0, bi_a: RST_BI_A};

  function automatic logic [11:0] out_w(input logic fmt);
    return fmt ? OUT_W_4K : OUT_W_1080P;
  endfunction

  function automatic logic [11:0] out_h(input logic fmt);
    return fmt ? OUT_H_4K : OUT_H_1080P;
  endfunction

endpackage

// File: rtl/scaler_cfg_sequencer_if.sv
// Configuration, frame-timing and scaler-handshake bundle of the sequencer.
interface scaler_cfg_sequencer_if
  import scaler_cfg_pkg::*;
#(
  parameter int FRAC_W = FRAC_W_DEF
);
  logic [11:0]     cfg_x_len;
  logic [11:0]     cfg_y_len;
  logic            cfg_len_update;
  logic [1:0]      cfg_algorithm;
  logic            cfg_vid_format;
  logic [8:0]      cfg_bi_a;
  logic            frame_end;
  logic            scaler_idle;
  logic            scaler_halt;
  logic [11:0]     act_x_len;
  logic [11:0]     act_y_len;
  logic [1:0]      act_algorithm;
  logic            act_vid_format;
  logic [8:0]      act_bi_a;
  logic [FRAC_W:0] step_x;
  logic [FRAC_W:0] step_y;
  logic            cfg_apply;
  logic            cfg_busy;
  logic            timeout_err;

  modport master (
    output cfg_x_len, cfg_y_len, cfg_len_update, cfg_algorithm, cfg_vid_format, cfg_bi_a,
    output frame_end, scaler_idle,
    input  scaler_halt, act_x_len, act_y_len, act_algorithm, act_vid_format, act_bi_a,
    input  step_x, step_y, cfg_apply, cfg_busy, timeout_err
  );

  modport slave (
    input  cfg_x_len, cfg_y_len, cfg_len_update, cfg_algorithm, cfg_vid_format, cfg_bi_a,
    input  frame_end, scaler_idle,
    output scaler_halt, act_x_len, act_y_len, act_algorithm, act_vid_format, act_bi_a,
    output step_x, step_y, cfg_apply, cfg_busy, timeout_err
  );
endinterface

// File: rtl/scaler_cfg_sequencer_div.sv
// Restoring serial divider: one quotient bit per cycle, DVD_W cycles per divide.
module fxp_div_serial #(
  parameter int DVD_W = 28,
  parameter int DVS_W = 12,
  parameter int Q_W   = 17
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             start_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Q_W-1:0]   quotient_o
);
  localparam int CNT_W = $clog2(DVD_W + 1);

  logic [DVD_W-1:0] work_q, work_d;
  logic [DVS_W-1:0] dvs_q, rem_q;
  logic [DVS_W:0]   trial, rem_d;
  logic [CNT_W-1:0] cnt_q;
  logic [Q_W-1:0]   quot_q;
  logic             busy_q, qbit;

  // work_q shifts dividend bits out of the top while quotient bits enter at the bottom
  always_comb begin
    trial  = {rem_q, work_q[DVD_W-1]};
    qbit   = (trial >= {1'b0, dvs_q});
    rem_d  = qbit ? (trial - {1'b0, dvs_q}) : trial;
    work_d = {work_q[DVD_W-2:0], qbit};
  end

  // done_o marks the final iteration; quotient_o holds the result from the next cycle on
  assign done_o     = busy_q && (cnt_q == CNT_W'(1));
  assign busy_o     = busy_q;
  assign quotient_o = quot_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      work_q <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      quot_q <= '0;
    end else begin
      if (start_i) begin
        work_q <= dividend_i;
        dvs_q  <= divisor_i;
        rem_q  <= '0;
        cnt_q  <= CNT_W'(DVD_W);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        work_q <= work_d;
        rem_q  <= rem_d[DVS_W-1:0];
        cnt_q  <= cnt_q - CNT_W'(1);
        if (done_o) busy_q <= 1'b0;
      end
      if (done_o) quot_q <= work_d[Q_W-1:0];
    end
  end

endmodule

// File: rtl/scaler_cfg_sequencer.sv
// Frame-synchronous configuration sequencer: shadows decoded config, halts the
// scaler after frame_end, derives step_x/step_y and commits everything at once.
module scaler_cfg_sequencer
  import scaler_cfg_pkg::*;
#(
  parameter int FRAC_W       = FRAC_W_DEF,
  parameter int IDLE_TIMEOUT = 1024
) (
  input logic sys_clk,
  input logic sys_rst,
  scaler_cfg_sequencer_if.slave bus
);
  localparam int DVD_W = 12 + FRAC_W;
  localparam int TMO_W = $clog2(IDLE_TIMEOUT);

  state_e           state_q, state_d;
  cfg_t             in_cfg, shadow_q, shadow_d, hold_q, act_q;
  logic [1:0]       alg_dly_q;
  logic             fmt_dly_q;
  logic [8:0]       bia_dly_q;
  logic             req, consuming, pend_again_q, tmo_hit;
  logic [TMO_W-1:0] tmo_q;
  logic             div_start, div_done, div_busy;
  logic [DVD_W-1:0] div_dividend;
  logic [11:0]      div_divisor;
  logic [FRAC_W:0]  div_quot, quot_x_q, step_x_q, step_y_q;
  logic             halt_q, halt_d, apply_q, apply_d, busy_q, busy_d, tmo_err_q, tmo_err_d;

  assign in_cfg = '{x_len: bus.cfg_x_len, y_len: bus.cfg_y_len, algorithm: bus.cfg_algorithm,
                    vid_format: bus.cfg_vid_format, bi_a: bus.cfg_bi_a};
  assign req = bus.cfg_len_update || (bus.cfg_algorithm != alg_dly_q) ||
               (bus.cfg_vid_format != fmt_dly_q) || (bus.cfg_bi_a != bia_dly_q);
  assign consuming = (state_q == ST_DIV_X) || (state_q == ST_DIV_Y) || (state_q == ST_COMMIT);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    tmo_hit = 1'b0;
    unique case (state_q)
      ST_IDLE:    if (req) state_d = ST_PENDING;
      ST_PENDING: if (bus.frame_end) state_d = ST_HALT;
      ST_HALT: begin
        if (bus.scaler_idle) begin
          state_d = ST_DIV_X;
        end else if (tmo_q == TMO_W'(IDLE_TIMEOUT - 1)) begin
          state_d = ST_DIV_X;
          tmo_hit = 1'b1;
        end
      end
      ST_DIV_X:   if (div_done) state_d = ST_DIV_Y;
      ST_DIV_Y:   if (div_done) state_d = ST_COMMIT;
      ST_COMMIT:  state_d = ST_RELEASE;
      // a request landing in RELEASE itself re-arms the sequencer as well
      ST_RELEASE: state_d = (pend_again_q || req) ? ST_PENDING : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    halt_d    = (state_d == ST_HALT) || (state_d == ST_DIV_X) ||
                (state_d == ST_DIV_Y) || (state_d == ST_COMMIT);
    busy_d    = (state_d != ST_IDLE);
    apply_d   = (state_d == ST_RELEASE);
    tmo_err_d = tmo_err_q || tmo_hit;
  end

  // Held requests land in RELEASE; a fresh request in the same cycle is newer and wins.
  always_comb begin
    shadow_d = shadow_q;
    if ((state_q == ST_RELEASE) && pend_again_q) shadow_d = hold_q;
    if (req && !consuming) shadow_d = in_cfg;
  end

  // Operands come from shadow_d so a request in the last HALT cycle is divided and committed.
  assign div_start    = ((state_q == ST_HALT) && (state_d == ST_DIV_X)) ||
                        ((state_q == ST_DIV_X) && (state_d == ST_DIV_Y));
  assign div_dividend = {(state_q == ST_HALT) ? shadow_d.x_len : shadow_d.y_len, {FRAC_W{1'b0}}};
  assign div_divisor  = (state_q == ST_HALT) ? out_w(shadow_d.vid_format) : out_h(shadow_d.vid_format);

  fxp_div_serial #(.DVD_W(DVD_W), .DVS_W(12), .Q_W(FRAC_W + 1)) u_div (
    .clk_i      (sys_clk),
    .srst_i     (sys_rst),
    .start_i    (div_start),
    .dividend_i (div_dividend),
    .divisor_i  (div_divisor),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quot)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      halt_q    <= 1'b0;
      apply_q   <= 1'b0;
      busy_q    <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      halt_q    <= halt_d;
      apply_q   <= apply_d;
      busy_q    <= busy_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      shadow_q     <= '0;
      hold_q       <= '0;
      pend_again_q <= 1'b0;
      alg_dly_q    <= RST_CFG.algorithm;
      fmt_dly_q    <= RST_CFG.vid_format;
      bia_dly_q    <= RST_CFG.bi_a;
      tmo_q        <= '0;
      quot_x_q     <= '0;
      act_q        <= RST_CFG;
      step_x_q     <= (FRAC_W + 1)'(RST_STEP_X);
      step_y_q     <= (FRAC_W + 1)'(RST_STEP_Y);
    end else begin
      shadow_q  <= shadow_d;
      alg_dly_q <= bus.cfg_algorithm;
      fmt_dly_q <= bus.cfg_vid_format;
      bia_dly_q <= bus.cfg_bi_a;
      tmo_q     <= (state_q == ST_HALT) ? (tmo_q + TMO_W'(1)) : '0;
      if (req && consuming) begin
        hold_q       <= in_cfg;
        pend_again_q <= 1'b1;
      end else if (state_q == ST_RELEASE) begin
        pend_again_q <= 1'b0;
      end
      // the divider still shows the x quotient until the y divide finishes
      if ((state_q == ST_DIV_Y) && div_busy) quot_x_q <= div_quot;
      if (state_q == ST_COMMIT) begin
        act_q    <= shadow_q;
        step_x_q <= quot_x_q;
        step_y_q <= div_quot;
      end
    end
  end

  assign bus.scaler_halt    = halt_q;
  assign bus.cfg_apply      = apply_q;
  assign bus.cfg_busy       = busy_q;
  assign bus.timeout_err    = tmo_err_q;
  assign bus.act_x_len      = act_q.x_len;
  assign bus.act_y_len      = act_q.y_len;
  assign bus.act_algorithm  = act_q.algorithm;
  assign bus.act_vid_format = act_q.vid_format;
  assign bus.act_bi_a       = act_q.bi_a;
  assign bus.step_x         = step_x_q;
  assign bus.step_y         = step_y_q;

endmodule

// File: tb/tb_scaler_cfg_sequencer.sv
// Scenario bench for scaler_cfg_sequencer: directed cases plus randomized requests
// checked against an arithmetic reference of the commit values and timing.
module tb_scaler_cfg_sequencer;
  logic sys_clk;
  logic sys_rst;
  int   checks = 0;
  int   errors = 0;

  scaler_cfg_sequencer_if bus ();
  scaler_cfg_sequencer dut (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus));

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge sys_clk);
  endtask

  // Reference: floor(len * 2^16 / output resolution) for the requested format.
  function automatic int exp_step(input int len, input int fmt, input bit is_y);
    longint out_res;
    out_res = is_y ? ((fmt != 0) ? 2160 : 1080) : ((fmt != 0) ? 3840 : 1920);
    return int'((longint'(len) * 65536) / out_res);
  endfunction

  task automatic send_req(input int x, input int y, input int alg, input int fmt, input int bia, input bit len_upd);
    bus.cfg_x_len      = 12'(x);
    bus.cfg_y_len      = 12'(y);
    bus.cfg_algorithm  = 2'(alg);
    bus.cfg_vid_format = 1'(fmt);
    bus.cfg_bi_a       = 9'(bia);
    bus.cfg_len_update = len_upd;
    tick();
    bus.cfg_len_update = 1'b0;
  endtask

  // Pulses frame_end at cycle T and returns the apply offset from T (or -1) and halt-high cycles.
  task automatic run_frame(input int idle_delay, output int lat, output int halt_cnt);
    lat = -1;
    halt_cnt = 0;
    bus.scaler_idle = (idle_delay == 0);
    bus.frame_end = 1'b1;
    tick();
    bus.frame_end = 1'b0;
    for (int off = 1; off < 3000; off++) begin
      if (off == 1 + idle_delay) bus.scaler_idle = 1'b1;
      if (bus.scaler_halt === 1'b1) halt_cnt++;
      if (bus.cfg_apply === 1'b1) begin
        lat = off;
        break;
      end
      tick();
    end
    bus.scaler_idle = 1'b1;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (5) tick();
    sys_rst = 1'b0;
    repeat (3) tick();
    checks++; if (int'(bus.act_x_len) !== 640) begin errors++; $display("FAIL reset_act_x_len: got %0d want 640", bus.act_x_len); end
    checks++; if (int'(bus.act_y_len) !== 480) begin errors++; $display("FAIL reset_act_y_len: got %0d want 480", bus.act_y_len); end
    checks++; if (int'(bus.step_x) !== 21845) begin errors++; $display("FAIL reset_step_x: got %0d want 21845", bus.step_x); end
    checks++; if (int'(bus.step_y) !== 29127) begin errors++; $display("FAIL reset_step_y: got %0d want 29127", bus.step_y); end
    checks++; if (int'(bus.act_bi_a) !== 128) begin errors++; $display("FAIL reset_act_bi_a: got %0d want 128", bus.act_bi_a); end
    checks++; if (bus.act_algorithm !== 2'd0) begin errors++; $display("FAIL reset_act_algorithm: got %0d want 0", bus.act_algorithm); end
    checks++; if (bus.act_vid_format !== 1'b0) begin errors++; $display("FAIL reset_act_vid_format: got %0b want 0", bus.act_vid_format); end
    checks++; if ({bus.scaler_halt, bus.cfg_apply, bus.cfg_busy, bus.timeout_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got halt/apply/busy/tmo=%b want 0000", {bus.scaler_halt, bus.cfg_apply, bus.cfg_busy, bus.timeout_err});
    end
    $display("txn reset: act=%0dx%0d step=%0d/%0d", bus.act_x_len, bus.act_y_len, bus.step_x, bus.step_y);
  endtask

  task automatic test_basic_latency();
    int lat, hc;
    send_req(1280, 720, 0, 0, 128, 1'b1);
    checks++; if (bus.cfg_busy !== 1'b1) begin errors++; $display("FAIL basic_busy_pending: got %0b want 1", bus.cfg_busy); end
    repeat (3) tick();
    checks++; if (int'(bus.act_x_len) !== 640) begin errors++; $display("FAIL basic_act_held: got %0d want 640", bus.act_x_len); end
    run_frame(0, lat, hc);
    checks++; if (lat !== 59) begin errors++; $display("FAIL basic_apply_latency: got %0d want 59", lat); end
    checks++; if (hc !== 58) begin errors++; $display("FAIL basic_halt_cycles: got %0d want 58", hc); end
    checks++; if (bus.scaler_halt !== 1'b0) begin errors++; $display("FAIL basic_halt_at_apply: got %0b want 0", bus.scaler_halt); end
    checks++; if (int'(bus.step_x) !== 43690) begin errors++; $display("FAIL basic_step_x: got %0d want 43690", bus.step_x); end
    checks++; if (int'(bus.step_y) !== 43690) begin errors++; $display("FAIL basic_step_y: got %0d want 43690", bus.step_y); end
    checks++; if (int'(bus.act_x_len) !== 1280 || int'(bus.act_y_len) !== 720) begin
      errors++; $display("FAIL basic_act_len: got %0dx%0d want 1280x720", bus.act_x_len, bus.act_y_len);
    end
    $display("txn basic: lat=%0d halt=%0d step=%0d/%0d", lat, hc, bus.step_x, bus.step_y);
    tick();
    checks++; if ({bus.cfg_apply, bus.cfg_busy} !== 2'b00) begin errors++; $display("FAIL basic_after_release: got apply/busy=%b want 00", {bus.cfg_apply, bus.cfg_busy}); end
  endtask

  task automatic test_format_4k();
    int lat, hc;
    send_req(1920, 1080, 0, 1, 128, 1'b0);
    repeat (2) tick();
    run_frame(0, lat, hc);
    checks++; if (lat !== 59) begin errors++; $display("FAIL fmt4k_latency: got %0d want 59", lat); end
    checks++; if (int'(bus.step_x) !== 32768) begin errors++; $display("FAIL fmt4k_step_x: got %0d want 32768", bus.step_x); end
    checks++; if (int'(bus.step_y) !== 32768) begin errors++; $display("FAIL fmt4k_step_y: got %0d want 32768", bus.step_y); end
    checks++; if (bus.act_vid_format !== 1'b1) begin errors++; $display("FAIL fmt4k_act_format: got %0b want 1", bus.act_vid_format); end
    $display("txn fmt4k: lat=%0d step=%0d/%0d fmt=%0b", lat, bus.step_x, bus.step_y, bus.act_vid_format);
    tick();
  endtask

  task automatic test_random();
    int lat, hc, d, nreq, m_x, m_y, m_alg, m_fmt, m_bia;
    for (int it = 0; it < 5; it++) begin
      nreq = int'($urandom_range(1, 3));
      for (int r = 0; r < nreq; r++) begin
        m_x = int'($urandom_range(161, 1920));
        m_y = int'($urandom_range(121, 1080));
        m_alg = int'($urandom_range(0, 2));
        m_fmt = int'($urandom_range(0, 1));
        m_bia = int'($urandom_range(0, 511));
        send_req(m_x, m_y, m_alg, m_fmt, m_bia, 1'b1);
        repeat ($urandom_range(0, 3)) tick();
      end
      d = int'($urandom_range(0, 6));
      run_frame(d, lat, hc);
      checks++; if (lat !== 59 + d) begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d", it, lat, 59 + d); end
      checks++; if (int'(bus.step_x) !== exp_step(m_x, m_fmt, 1'b0)) begin errors++; $display("FAIL rand%0d_step_x: got %0d want %0d", it, bus.step_x, exp_step(m_x, m_fmt, 1'b0)); end
      checks++; if (int'(bus.step_y) !== exp_step(m_y, m_fmt, 1'b1)) begin errors++; $display("FAIL rand%0d_step_y: got %0d want %0d", it, bus.step_y, exp_step(m_y, m_fmt, 1'b1)); end
      checks++; if (int'(bus.act_x_len) !== m_x || int'(bus.act_y_len) !== m_y) begin
        errors++; $display("FAIL rand%0d_act_len: got %0dx%0d want %0dx%0d", it, bus.act_x_len, bus.act_y_len, m_x, m_y);
      end
      checks++; if (int'(bus.act_algorithm) !== m_alg || int'(bus.act_vid_format) !== m_fmt || int'(bus.act_bi_a) !== m_bia) begin
        errors++; $display("FAIL rand%0d_act_mode: got alg=%0d fmt=%0d a=%0d want alg=%0d fmt=%0d a=%0d", it,
                           bus.act_algorithm, bus.act_vid_format, bus.act_bi_a, m_alg, m_fmt, m_bia);
      end
      $display("txn random%0d: req=%0d idle_delay=%0d cfg=%0dx%0d fmt=%0d lat=%0d step=%0d/%0d", it, nreq, d, m_x, m_y, m_fmt, lat, bus.step_x, bus.step_y);
      tick();
      checks++; if (bus.cfg_busy !== 1'b0) begin errors++; $display("FAIL rand%0d_idle_after: got busy=%0b want 0", it, bus.cfg_busy); end
    end
  endtask

  task automatic test_timeout();
    int lat, hc;
    send_req(800, 600, 2, 0, 77, 1'b1);
    tick();
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_before: got %0b want 0", bus.timeout_err); end
    run_frame(100000, lat, hc);
    checks++; if (lat !== 1082) begin errors++; $display("FAIL tmo_latency: got %0d want 1082", lat); end
    checks++; if (hc !== 1081) begin errors++; $display("FAIL tmo_halt_cycles: got %0d want 1081", hc); end
    checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_flag: got %0b want 1", bus.timeout_err); end
    checks++; if (int'(bus.step_x) !== exp_step(800, 0, 1'b0)) begin errors++; $display("FAIL tmo_step_x: got %0d want %0d", bus.step_x, exp_step(800, 0, 1'b0)); end
    $display("txn timeout: lat=%0d halt=%0d tmo=%0b", lat, hc, bus.timeout_err);
    repeat (20) tick();
    checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %0b want 1", bus.timeout_err); end
  endtask

  task automatic test_back_to_back();
    int lat, hc;
    send_req(1280, 720, 1, 0, 200, 1'b1);
    repeat (2) tick();
    lat = -1;
    bus.scaler_idle = 1'b1;
    bus.frame_end = 1'b1;
    tick();
    bus.frame_end = 1'b0;
    for (int off = 1; off < 200; off++) begin
      if (off == 5) begin
        bus.cfg_x_len = 12'd640; bus.cfg_y_len = 12'd480; bus.cfg_algorithm = 2'd0;
        bus.cfg_vid_format = 1'b0; bus.cfg_bi_a = 9'd128; bus.cfg_len_update = 1'b1;
      end
      if (off == 6) bus.cfg_len_update = 1'b0;
      if (bus.cfg_apply === 1'b1) begin
        lat = off;
        break;
      end
      tick();
    end
    checks++; if (lat !== 59) begin errors++; $display("FAIL b2b_first_latency: got %0d want 59", lat); end
    checks++; if (int'(bus.act_x_len) !== 1280 || int'(bus.act_y_len) !== 720) begin
      errors++; $display("FAIL b2b_first_len: got %0dx%0d want 1280x720", bus.act_x_len, bus.act_y_len);
    end
    checks++; if (int'(bus.step_x) !== exp_step(1280, 0, 1'b0)) begin errors++; $display("FAIL b2b_first_step_x: got %0d want %0d", bus.step_x, exp_step(1280, 0, 1'b0)); end
    checks++; if (int'(bus.act_algorithm) !== 1 || int'(bus.act_bi_a) !== 200) begin
      errors++; $display("FAIL b2b_first_mode: got alg=%0d a=%0d want alg=1 a=200", bus.act_algorithm, bus.act_bi_a);
    end
    $display("txn b2b first: lat=%0d act=%0dx%0d", lat, bus.act_x_len, bus.act_y_len);
    tick();
    checks++; if ({bus.cfg_apply, bus.cfg_busy} !== 2'b01) begin errors++; $display("FAIL b2b_repending: got apply/busy=%b want 01", {bus.cfg_apply, bus.cfg_busy}); end
    repeat (3) tick();
    run_frame(0, lat, hc);
    checks++; if (lat !== 59) begin errors++; $display("FAIL b2b_second_latency: got %0d want 59", lat); end
    checks++; if (int'(bus.act_x_len) !== 640 || int'(bus.act_y_len) !== 480) begin
      errors++; $display("FAIL b2b_second_len: got %0dx%0d want 640x480", bus.act_x_len, bus.act_y_len);
    end
    checks++; if (int'(bus.step_x) !== 21845 || int'(bus.step_y) !== 29127) begin
      errors++; $display("FAIL b2b_second_step: got %0d/%0d want 21845/29127", bus.step_x, bus.step_y);
    end
    $display("txn b2b second: lat=%0d act=%0dx%0d step=%0d/%0d", lat, bus.act_x_len, bus.act_y_len, bus.step_x, bus.step_y);
    tick();
  endtask

  task automatic test_reset_mid_divide();
    int applies;
    send_req(1000, 700, 0, 0, 128, 1'b1);
    repeat (2) tick();
    bus.scaler_idle = 1'b1;
    bus.frame_end = 1'b1;
    tick();
    bus.frame_end = 1'b0;
    repeat (39) tick();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    checks++; if (int'(bus.act_x_len) !== 640 || int'(bus.act_y_len) !== 480) begin
      errors++; $display("FAIL rstdiv_act_len: got %0dx%0d want 640x480", bus.act_x_len, bus.act_y_len);
    end
    checks++; if (int'(bus.step_x) !== 21845 || int'(bus.step_y) !== 29127) begin
      errors++; $display("FAIL rstdiv_step: got %0d/%0d want 21845/29127", bus.step_x, bus.step_y);
    end
    checks++; if ({bus.scaler_halt, bus.cfg_apply, bus.cfg_busy, bus.timeout_err} !== 4'b0000) begin
      errors++; $display("FAIL rstdiv_flags: got halt/apply/busy/tmo=%b want 0000", {bus.scaler_halt, bus.cfg_apply, bus.cfg_busy, bus.timeout_err});
    end
    applies = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.cfg_apply === 1'b1) applies++;
      tick();
    end
    checks++; if (applies !== 0) begin errors++; $display("FAIL rstdiv_no_apply: got %0d pulses want 0", applies); end
    checks++; if (bus.cfg_busy !== 1'b0) begin errors++; $display("FAIL rstdiv_idle: got busy=%0b want 0", bus.cfg_busy); end
    $display("txn reset_mid_divide: act=%0dx%0d applies=%0d", bus.act_x_len, bus.act_y_len, applies);
  endtask

  initial begin
    sys_rst            = 1'b1;
    bus.cfg_x_len      = 12'd640;
    bus.cfg_y_len      = 12'd480;
    bus.cfg_len_update = 1'b0;
    bus.cfg_algorithm  = 2'd0;
    bus.cfg_vid_format = 1'b0;
    bus.cfg_bi_a       = 9'd128;
    bus.frame_end      = 1'b0;
    bus.scaler_idle    = 1'b1;
    test_reset();
    test_basic_latency();
    test_format_4k();
    test_random();
    test_timeout();
    test_back_to_back();
    test_reset_mid_divide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
